// File: rtl/imem_loader_rom.sv
// imem_loader_rom: instruction store answering the fetch PC combinationally,
// reloadable from a little-endian byte stream. Fetch is stalled whenever the
// store is not in RUN.
//
// Byte-stream handshake: a byte moves on a rising edge where
// load_valid && load_ready. load_ready is high only in LOAD. The source may
// change load_byte freely while load_valid is low.
module imem_loader_rom #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter bit          BOOT_RUN  = 1'b0,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_imem,
  output logic [XLEN-1:0] instr_imem,
  output logic            stall_if,
  input  logic            load_start,
  input  logic [15:0]     load_len,
  input  logic [7:0]      load_byte,
  input  logic            load_valid,
  output logic            load_ready,
  output logic            load_done,
  output logic            fault
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;
  localparam state_t RST_STATE = BOOT_RUN ? S_RUN : S_IDLE;

  // The store has no reset: its contents survive rst, including a partially
  // completed load.
  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [AW:0] word_ptr_q, word_ptr_d;   // one bit wider so it can reach DEPTH
  logic [AW:0] target_q, target_d;
  logic [23:0] asm_q, asm_d;             // bytes 0..2 of the word being built
  logic        fault_q, fault_d;

  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [AW:0]   start_target;
  logic          pc_ok;
  logic [AW-1:0] rd_idx;

  // Read path: legal only for an aligned PC inside the store.
  always_comb begin
    rd_idx     = pc_imem[AW+1:2];
    pc_ok      = (pc_imem[1:0] == 2'b00) && ((pc_imem >> (AW + 2)) == '0);
    instr_imem = XLEN'(NOP);
    if (state_q == S_RUN && pc_ok) begin
      instr_imem = XLEN'(mem[rd_idx]);
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_ptr_d = word_ptr_q;
    target_d   = target_q;
    asm_d      = asm_q;
    fault_d    = fault_q;
    mem_we     = 1'b0;
    mem_wdata  = {load_byte, asm_q};
    stall_if   = 1'b1;
    load_ready = 1'b0;
    load_done  = 1'b0;

    // Requested length clamped to the store size.
    if (32'(load_len) >= DEPTH) begin
      start_target = (AW+1)'(DEPTH);
    end else begin
      start_target = (AW+1)'(load_len);
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          target_d   = start_target;
          word_ptr_d = '0;
          byte_cnt_d = '0;
          state_d    = (load_len == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we     = 1'b1;
            word_ptr_d = word_ptr_q + 1'b1;
            if ((word_ptr_q + 1'b1) == target_q) begin
              state_d = S_DONE;
            end
          end else begin
            asm_d[8*byte_cnt_q +: 8] = load_byte;
          end
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        stall_if = 1'b0;
        if (load_start) begin
          target_d   = start_target;
          word_ptr_d = '0;
          byte_cnt_d = '0;
          fault_d    = 1'b0;
          state_d    = (load_len == 16'd0) ? S_DONE : S_LOAD;
        end else if (!pc_ok) begin
          fault_d = 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign fault = fault_q;

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      byte_cnt_q <= '0;
      word_ptr_q <= '0;
      target_q   <= '0;
      asm_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      target_q   <= target_d;
      asm_q      <= asm_d;
      fault_q    <= fault_d;
    end
  end

  // Store write port, one full word per completed 4-byte group.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end
endmodule
